// File: rtl/servo_motion_ctrl_if.sv
// servo_motion_ctrl_if: client request/ack pairs and commanded-angle status of the servo sequencer
interface servo_motion_ctrl_if;
  logic       req_a;
  logic [7:0] angle_a;
  logic       ack_a;
  logic       req_b;
  logic [7:0] angle_b;
  logic       ack_b;
  logic [7:0] angle_out;
  logic       frame_tick;
  logic       busy;
  logic       done;
  logic       owner;
  modport master (
    output req_a, angle_a, req_b, angle_b,
    input  ack_a, ack_b, angle_out, frame_tick, busy, done, owner
  );
  modport slave (
    input  req_a, angle_a, req_b, angle_b,
    output ack_a, ack_b, angle_out, frame_tick, busy, done, owner
  );
endinterface

// File: rtl/servo_motion_ctrl.sv
// servo_motion_ctrl: round-robin arbiter for two clients that steps the servo angle toward the target once per frame
module servo_motion_ctrl #(
  parameter int FRAME_CYCLES  = 1000000,
  parameter int STEP          = 2,
  parameter int MAX_ANGLE     = 180,
  parameter int INIT_ANGLE    = 90,
  parameter int SETTLE_FRAMES = 5
) (
  input logic clk,
  input logic rst,
  servo_motion_ctrl_if.slave s
);
  localparam int CW = FRAME_CYCLES > 1 ? $clog2(FRAME_CYCLES) : 1;
  localparam int SW = SETTLE_FRAMES > 0 ? $clog2(SETTLE_FRAMES + 1) : 1;
  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [7:0] MAX8  = 8'(MAX_ANGLE);
  localparam logic [7:0] INIT8 = 8'(INIT_ANGLE);
  typedef enum logic [1:0] {IDLE, MOVE, SETTLE} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] settle_cnt;
  logic [7:0]    target;
  logic          last_grant;
  logic          up;
  logic [8:0]    diff;
  logic          grant_a;
  logic          grant_b;
  logic [7:0]    clamp_a;
  logic [7:0]    clamp_b;
  always_comb begin
    up      = target > s.angle_out;
    diff    = up ? {1'b0, target} - {1'b0, s.angle_out} : {1'b0, s.angle_out} - {1'b0, target};
    grant_a = s.req_a & (~s.req_b | last_grant);
    grant_b = s.req_b & (~s.req_a | ~last_grant);
    clamp_a = s.angle_a > MAX8 ? MAX8 : s.angle_a;
    clamp_b = s.angle_b > MAX8 ? MAX8 : s.angle_b;
  end
  // frame_tick is registered one count early so it is high exactly while cnt is the last count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      s.frame_tick <= 1'b0;
    end else begin
      cnt          <= cnt == CW'(FRAME_CYCLES - 1) ? '0 : cnt + 1'b1;
      s.frame_tick <= FRAME_CYCLES == 1 ? 1'b1 : cnt == CW'(FRAME_CYCLES - 2);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      s.angle_out <= INIT8;
      target      <= INIT8;
      settle_cnt  <= '0;
      last_grant  <= 1'b1;
      s.ack_a     <= 1'b0;
      s.ack_b     <= 1'b0;
      s.busy      <= 1'b0;
      s.done      <= 1'b0;
      s.owner     <= 1'b0;
    end else begin
      s.ack_a <= 1'b0;
      s.ack_b <= 1'b0;
      s.done  <= 1'b0;
      case (state)
        IDLE: if (grant_a | grant_b) begin
          s.ack_a    <= grant_a;
          s.ack_b    <= grant_b;
          target     <= grant_b ? clamp_b : clamp_a;
          s.owner    <= grant_b;
          last_grant <= grant_b;
          s.busy     <= 1'b1;
          state      <= MOVE;
        end
        MOVE: if (s.frame_tick) begin
          if (diff <= STEP9) begin
            s.angle_out <= target;
            settle_cnt  <= SW'(SETTLE_FRAMES);
            state       <= SETTLE;
          end else
            s.angle_out <= up ? s.angle_out + 8'(STEP) : s.angle_out - 8'(STEP);
        end
        SETTLE: if (settle_cnt == '0) begin
          s.done <= 1'b1;
          s.busy <= 1'b0;
          state  <= IDLE;
        end else if (s.frame_tick)
          settle_cnt <= settle_cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_servo_motion_ctrl.sv
// tb_servo_motion_ctrl: directed scenarios for the servo sequencer with FRAME_CYCLES=100, STEP=2, SETTLE_FRAMES=2
module tb_servo_motion_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passed = 0;
  servo_motion_ctrl_if bus();
  servo_motion_ctrl #(
    .FRAME_CYCLES(100), .STEP(2), .MAX_ANGLE(180), .INIT_ANGLE(90), .SETTLE_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .s(bus)
  );
  always #5 clk = ~clk;

  task automatic do_reset();
    bus.req_a = 1'b0; bus.req_b = 1'b0; bus.angle_a = 8'd0; bus.angle_b = 8'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (bus.frame_tick) begin n = i; break; end
    end
  endtask

  task automatic tick_angle(output int a);
    int n;
    wait_tick(n);
    @(negedge clk);
    a = n < 0 ? -1 : int'(bus.angle_out);
  endtask

  task automatic wait_done(output int n, input int budget);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.done) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    int k;
    do_reset();
    repeat (37) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.angle_out !== 8'd90) $display("FAIL reset_angle got %0d want 90", bus.angle_out); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
    checks++; if ({bus.ack_a, bus.ack_b, bus.done} !== 3'b000) $display("FAIL reset_pulses got %b want 000", {bus.ack_a, bus.ack_b, bus.done}); else passed++;
    checks++; if (bus.owner !== 1'b0) $display("FAIL reset_owner got %b want 0", bus.owner); else passed++;
    @(negedge clk);
    rst = 1'b0;
    k = -1;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (bus.frame_tick) begin k = i; break; end
    end
    checks++; if (k !== 99) $display("FAIL reset_first_tick got %0d want 99", k); else passed++;
    @(negedge clk);
    checks++; if (bus.frame_tick !== 1'b0) $display("FAIL tick_width got %b want 0", bus.frame_tick); else passed++;
  endtask

  task automatic test_single_move();
    int a, n;
    do_reset();
    bus.angle_a = 8'd100; bus.req_a = 1'b1;
    @(negedge clk);
    checks++; if ({bus.ack_a, bus.ack_b} !== 2'b10) $display("FAIL single_ack got %b want 10", {bus.ack_a, bus.ack_b}); else passed++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL single_busy_rise got %b want 1", bus.busy); else passed++;
    bus.req_a = 1'b0;
    @(negedge clk);
    checks++; if (bus.ack_a !== 1'b0) $display("FAIL single_ack_width got %b want 0", bus.ack_a); else passed++;
    for (int i = 1; i <= 5; i++) begin
      tick_angle(a);
      checks++; if (a !== 90 + 2 * i) $display("FAIL single_step%0d got %0d want %0d", i, a, 90 + 2 * i); else passed++;
    end
    wait_done(n, 400);
    checks++; if (n !== 201) $display("FAIL single_done_latency got %0d want 201", n); else passed++;
    checks++; if ({bus.busy, bus.owner} !== 2'b00) $display("FAIL single_busy_owner got %b want 00", {bus.busy, bus.owner}); else passed++;
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) $display("FAIL single_done_width got %b want 0", bus.done); else passed++;
  endtask

  task automatic test_clamp();
    int a, n;
    do_reset();
    bus.angle_b = 8'd250; bus.req_b = 1'b1;
    @(negedge clk);
    checks++; if ({bus.ack_a, bus.ack_b, bus.owner} !== 3'b011) $display("FAIL clamp_ack got %b want 011", {bus.ack_a, bus.ack_b, bus.owner}); else passed++;
    bus.req_b = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      tick_angle(a);
      checks++; if (a !== 90 + 2 * i) $display("FAIL clamp_step%0d got %0d want %0d", i, a, 90 + 2 * i); else passed++;
    end
    wait_done(n, 400);
    checks++; if (n !== 201) $display("FAIL clamp_done_latency got %0d want 201", n); else passed++;
    checks++; if (bus.angle_out !== 8'd180) $display("FAIL clamp_final got %0d want 180", bus.angle_out); else passed++;
    bus.angle_b = 8'd179; bus.req_b = 1'b1;
    @(negedge clk);
    checks++; if (bus.ack_b !== 1'b1) $display("FAIL odd_ack got %b want 1", bus.ack_b); else passed++;
    bus.req_b = 1'b0;
    tick_angle(a);
    checks++; if (a !== 179) $display("FAIL odd_step got %0d want 179", a); else passed++;
    wait_done(n, 400);
    checks++; if (n !== 201) $display("FAIL odd_done_latency got %0d want 201", n); else passed++;
    checks++; if ({bus.angle_out, bus.owner} !== {8'd179, 1'b1}) $display("FAIL odd_final got %0d/%b want 179/1", bus.angle_out, bus.owner); else passed++;
  endtask

  task automatic test_same_angle();
    int a, n;
    do_reset();
    bus.angle_a = 8'd90; bus.req_a = 1'b1;
    @(negedge clk);
    checks++; if ({bus.ack_a, bus.busy} !== 2'b11) $display("FAIL same_ack got %b want 11", {bus.ack_a, bus.busy}); else passed++;
    bus.req_a = 1'b0;
    tick_angle(a);
    checks++; if (a !== 90) $display("FAIL same_step got %0d want 90", a); else passed++;
    wait_done(n, 400);
    checks++; if (n !== 201) $display("FAIL same_done_latency got %0d want 201", n); else passed++;
    checks++; if (bus.angle_out !== 8'd90) $display("FAIL same_final got %0d want 90", bus.angle_out); else passed++;
  endtask

  task automatic test_arbitration();
    int a, n;
    do_reset();
    bus.angle_a = 8'd94; bus.angle_b = 8'd80;
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    @(negedge clk);
    checks++; if ({bus.ack_a, bus.ack_b, bus.owner} !== 3'b100) $display("FAIL arb_first got %b want 100", {bus.ack_a, bus.ack_b, bus.owner}); else passed++;
    bus.req_a = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick_angle(a);
      checks++; if (a !== 90 + 2 * i) $display("FAIL arb_a_step%0d got %0d want %0d", i, a, 90 + 2 * i); else passed++;
    end
    wait_done(n, 400);
    checks++; if ({n, bus.busy, bus.ack_b} !== {32'sd201, 1'b0, 1'b0}) $display("FAIL arb_a_done got %0d/%b/%b want 201/0/0", n, bus.busy, bus.ack_b); else passed++;
    @(negedge clk);
    checks++; if ({bus.ack_b, bus.owner, bus.busy} !== 3'b111) $display("FAIL arb_b_grant got %b want 111", {bus.ack_b, bus.owner, bus.busy}); else passed++;
    bus.req_b = 1'b0;
    tick_angle(a);
    checks++; if (a !== 92) $display("FAIL arb_b_step1 got %0d want 92", a); else passed++;
    bus.angle_a = 8'd84; bus.req_a = 1'b1; bus.req_b = 1'b1;
    for (int i = 2; i <= 7; i++) begin
      tick_angle(a);
      checks++; if (a !== 94 - 2 * i) $display("FAIL arb_b_step%0d got %0d want %0d", i, a, 94 - 2 * i); else passed++;
    end
    wait_done(n, 400);
    checks++; if ({n, bus.ack_a} !== {32'sd201, 1'b0}) $display("FAIL arb_b_done got %0d/%b want 201/0", n, bus.ack_a); else passed++;
    @(negedge clk);
    checks++; if ({bus.ack_a, bus.ack_b, bus.owner} !== 3'b100) $display("FAIL arb_rr_a got %b want 100", {bus.ack_a, bus.ack_b, bus.owner}); else passed++;
    bus.req_a = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick_angle(a);
      checks++; if (a !== 80 + 2 * i) $display("FAIL arb_a2_step%0d got %0d want %0d", i, a, 80 + 2 * i); else passed++;
    end
    wait_done(n, 400);
    checks++; if (n !== 201) $display("FAIL arb_a2_done got %0d want 201", n); else passed++;
    @(negedge clk);
    checks++; if ({bus.ack_a, bus.ack_b, bus.owner} !== 3'b011) $display("FAIL arb_rr_b got %b want 011", {bus.ack_a, bus.ack_b, bus.owner}); else passed++;
    bus.req_b = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick_angle(a);
      checks++; if (a !== 84 - 2 * i) $display("FAIL arb_b2_step%0d got %0d want %0d", i, a, 84 - 2 * i); else passed++;
    end
    wait_done(n, 400);
    checks++; if (n !== 201) $display("FAIL arb_b2_done got %0d want 201", n); else passed++;
  endtask

  task automatic test_reset_mid_move();
    int a;
    bit seen;
    do_reset();
    bus.angle_a = 8'd120; bus.req_a = 1'b1;
    @(negedge clk);
    checks++; if (bus.ack_a !== 1'b1) $display("FAIL mid_ack got %b want 1", bus.ack_a); else passed++;
    bus.req_a = 1'b0;
    for (int i = 1; i <= 3; i++) tick_angle(a);
    checks++; if (a !== 96) $display("FAIL mid_angle got %0d want 96", a); else passed++;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.angle_out, bus.busy, bus.done} !== {8'd90, 1'b0, 1'b0}) $display("FAIL mid_reset got %0d/%b/%b want 90/0/0", bus.angle_out, bus.busy, bus.done); else passed++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.angle_out != 8'd90) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL mid_abandon got %b want 0", seen); else passed++;
    bus.angle_a = 8'd100; bus.req_a = 1'b1;
    @(negedge clk);
    checks++; if ({bus.ack_a, bus.owner, bus.busy} !== 3'b101) $display("FAIL mid_reack got %b want 101", {bus.ack_a, bus.owner, bus.busy}); else passed++;
    bus.req_a = 1'b0;
    tick_angle(a);
    checks++; if (a !== 92) $display("FAIL mid_restep got %0d want 92", a); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_move();
    test_clamp();
    test_same_angle();
    test_arbitration();
    test_reset_mid_move();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/servo_motion_ctrl.md
# servo_motion_ctrl

Sequencer and two-port arbiter in front of the servo PWM generator. It accepts target-angle requests from two clients, for example the pet-behaviour FSM and the manual button path. It grants one request at a time and drives the PWM block's 8-bit angle input, moving it toward the target by a bounded step once per 20 ms PWM frame. When the commanded angle has reached the target and held for a configurable settle time, it signals completion.

## Interface
- FRAME_CYCLES, 1000000: clocks per servo frame (20 ms at 50 MHz); must match the PWM generator period.
- STEP, 2: maximum angle change per frame, in degrees; range 1..MAX_ANGLE.
- MAX_ANGLE, 180: upper clamp on accepted targets.
- INIT_ANGLE, 90: commanded angle after reset; must be ≤ MAX_ANGLE.
- SETTLE_FRAMES, 5: frames to hold at target before signalling done; 0 allowed.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req_a  in  1  client A request; level, held until ack_a.
- angle_a  in  8  client A target angle; stable while req_a is high.
- ack_a  out  1  one-cycle grant/accept pulse to client A.
- req_b  in  1  client B request; same rules as A.
- angle_b  in  8  client B target angle.
- ack_b  out  1  one-cycle grant/accept pulse to client B.
- angle_out  out  8  commanded angle, wired to the PWM generator angle input.
- frame_tick  out  1  one-cycle pulse at the end of each frame.
- busy  out  1  a granted move or settle is in progress.
- done  out  1  one-cycle pulse when the granted move completes.
- owner  out  1  client of the current or most recent grant (0 = A, 1 = B).

## Operation
- Frame counter: free-running 0..FRAME_CYCLES-1, wraps to 0. frame_tick=1 while the counter equals FRAME_CYCLES-1. The counter runs in every state.
- The state machine has three states: IDLE, MOVE, SETTLE.
- IDLE:
  - Requests are sampled.
  - If only one req is high, grant it.
  - If both are high, grant the client that is not last_grant (round-robin). last_grant resets to B, so A wins the first tie.
  - On grant: ack_x=1, target ← min(angle_x, MAX_ANGLE), owner ← x, last_grant ← x, state ← MOVE.
- MOVE:
  - Action occurs only on frame_tick cycles.
  - Let diff = |target − angle_out|.
  - If diff ≤ STEP: angle_out ← target, state ← SETTLE, settle_cnt ← SETTLE_FRAMES.
  - Otherwise angle_out ← angle_out ± STEP, toward the target.
  - A request whose target equals the current angle still enters MOVE and exits on the next frame_tick.
- SETTLE:
  - If settle_cnt == 0: done=1, state ← IDLE. This check applies immediately, without waiting for a tick.
  - Otherwise decrement settle_cnt on each frame_tick.
- Requests arriving in MOVE or SETTLE are not acked. They wait in req, and a pending request from the other client wins the next arbitration.
- Arithmetic:
  - Compute the difference in 9 bits to avoid wrap.
  - angle_out never leaves the range 0..MAX_ANGLE and never overshoots the target.
- Reset (at any time, including mid-move):
  - state IDLE, angle_out = INIT_ANGLE, counter 0, settle_cnt 0.
  - ack_a = ack_b = 0, busy 0, done 0, owner 0, last_grant B.
  - The interrupted move is abandoned with no done pulse.

## Timing
- All outputs are registered.
- ack_x asserts in the cycle after the edge that samples req_x high in IDLE, for exactly 1 cycle.
- busy rises in the same cycle as ack_x. It falls in the same cycle as done.
- angle_out changes only in the cycle following a frame_tick cycle. The PWM generator therefore sees a new angle at a frame boundary.
- Move latency: ceil(diff/STEP) frame_ticks in MOVE, plus one tick when diff == 0. SETTLE then adds SETTLE_FRAMES ticks, plus 1 clock to issue done.
- The earliest next ack is the cycle immediately after done. Back-to-back grants are therefore 1 idle cycle apart.
- A client must drop req in the cycle after its ack; if req is still high in IDLE, it is regranted as a new request.

## Test plan
All scenarios use FRAME_CYCLES=100, STEP=2, SETTLE_FRAMES=2.
- Reset: assert rst asynchronously mid-frame → angle_out=90, busy=0, all acks/done=0 immediately; after release, frame_tick first pulses at clock 99.
- Single move: req_a with angle 100 → ack_a next cycle. angle_out steps 92, 94 … 100 over 5 ticks, then 2 settle ticks. done pulses and busy falls together, owner=0.
- Clamp and odd residue: req_b with angle 250 from 90 → target 180, 45 ticks, final angle 180 with no overshoot. Then req_b with angle 179 → one tick to 179.
- Arbitration: req_a and req_b raised in the same cycle, both held → A acked first. B is acked the cycle after A's done. A re-requesting during B's move is served after B.
- Same-angle request: req_a with angle 90 at reset state → MOVE, exit at next tick, SETTLE 2 ticks, done. angle_out stays 90 throughout.
- Reset mid-move: assert rst while angle_out=96 moving to 120 → angle_out=90, no done pulse. A subsequent req_a is acked normally.
